module_bcd_binario: RTL and testbench

Sequential BCD-to-binary converter: the inverse of the binary-to-BCD divider that feeds the seven-segment path. It accepts N packed BCD digits on a start pulse, accumulates them most-significant digit first with one multiply-by-10-and-add step per clock, and presents the binary value with a one-cycle `listo` pulse. It sits between digit-entry logic (dipswitch/keypad digit capture) and the arithmetic units, so operands entered in decimal reach the adder as binary.

---
 rtl/module_bcd_binario_pkg.sv | 16 +
 rtl/module_bcd_binario_mul10_suma.sv | 12 +
 rtl/module_bcd_binario.sv | 95 +++++++++
 tb/tb_module_bcd_binario.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/module_bcd_binario_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
package pkg_bcd;

    typedef enum logic {IDLE, CONV} estado_bcd_t;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam int         BCD_W   = 4;

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

endpackage

// File: rtl/module_bcd_binario_mul10_suma.sv
// Combinational acc*10 + digit built from two shifts and adds, truncated to WIDTH.
module mul10_suma #(
    parameter int WIDTH = 14
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [3:0]       digit,
    output logic [WIDTH-1:0] result
);

    assign result = (acc << 3) + (acc << 1) + WIDTH'(digit);

endmodule

// File: rtl/module_bcd_binario.sv
// Sequential BCD-to-binary converter: one multiply-by-10-and-add step per clock,
// most significant digit first, with a one-cycle completion pulse.
module module_bcd_binario
    import pkg_bcd::*;
#(
    parameter int N_DIGITS = 4,
    parameter int WIDTH    = 14
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      iniciar,
    input  logic [BCD_W*N_DIGITS-1:0] bcd_input,
    output logic [WIDTH-1:0]          numero_output,
    output logic                      listo,
    output logic                      ocupado,
    output logic                      error_bcd
);

    localparam int              CNT_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int              DIG_W   = BCD_W * N_DIGITS;
    localparam longint unsigned MAX_DEC = pow10(N_DIGITS) - 64'd1;

    // The widest decimal value must fit in the output, otherwise refuse to elaborate.
    generate
        if (WIDTH < 64) begin : g_width_check
            if ((64'd1 << WIDTH) <= MAX_DEC) begin : g_width_too_small
                $error("module_bcd_binario: WIDTH too small for N_DIGITS");
            end
        end
    endgenerate

    estado_bcd_t      state_reg;
    logic [DIG_W-1:0] shift_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             invalid_reg;
    logic [WIDTH-1:0] acc_next;
    logic [N_DIGITS-1:0] digit_bad;

    genvar gi;
    generate
        for (gi = 0; gi < N_DIGITS; gi++) begin : g_digit_check
            assign digit_bad[gi] = bcd_input[gi*BCD_W +: BCD_W] > BCD_MAX;
        end
    endgenerate

    mul10_suma #(.WIDTH(WIDTH)) u_mul10_suma (
        .acc    (acc_reg),
        .digit  (shift_reg[DIG_W-1 -: BCD_W]),
        .result (acc_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            shift_reg     <= '0;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            invalid_reg   <= 1'b0;
            numero_output <= '0;
            listo         <= 1'b0;
            ocupado       <= 1'b0;
            error_bcd     <= 1'b0;
        end else begin
            listo <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (iniciar) begin
                        shift_reg   <= bcd_input;
                        acc_reg     <= '0;
                        cnt_reg     <= CNT_W'(N_DIGITS - 1);
                        invalid_reg <= |digit_bad;
                        ocupado     <= 1'b1;
                        state_reg   <= CONV;
                    end
                end
                CONV: begin
                    acc_reg   <= acc_next;
                    shift_reg <= shift_reg << BCD_W;
                    cnt_reg   <= cnt_reg - 1'b1;
                    if (cnt_reg == '0) begin
                        // A bad digit discards the arithmetic result entirely.
                        numero_output <= invalid_reg ? '0 : acc_next;
                        error_bcd     <= invalid_reg;
                        listo         <= 1'b1;
                        ocupado       <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_module_bcd_binario.sv
// Self-checking bench: expected results are queued at each accepted start and
// compared when listo pulses, for the default instance and a 2-digit instance.
module tb_module_bcd_binario;
    import pkg_bcd::*;

    typedef struct {
        int unsigned valor;
        bit          err;
    } esperado_t;

    logic        clk;
    logic        rst;
    logic        iniciar;
    logic [15:0] bcd_input;
    logic [13:0] numero_output;
    logic        listo;
    logic        ocupado;
    logic        error_bcd;

    logic        iniciar2;
    logic [7:0]  bcd_input2;
    logic [6:0]  numero_output2;
    logic        listo2;
    logic        ocupado2;
    logic        error_bcd2;

    esperado_t   cola[$];
    int          passed;
    int          total;

    module_bcd_binario dut (
        .clk           (clk),
        .rst           (rst),
        .iniciar       (iniciar),
        .bcd_input     (bcd_input),
        .numero_output (numero_output),
        .listo         (listo),
        .ocupado       (ocupado),
        .error_bcd     (error_bcd)
    );

    module_bcd_binario #(.N_DIGITS(2), .WIDTH(7)) dut2 (
        .clk           (clk),
        .rst           (rst),
        .iniciar       (iniciar2),
        .bcd_input     (bcd_input2),
        .numero_output (numero_output2),
        .listo         (listo2),
        .ocupado       (ocupado2),
        .error_bcd     (error_bcd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decimal interpretation of n packed digits.
    function automatic esperado_t modelo(input logic [15:0] v, input int n);
        esperado_t e;
        logic [15:0] t;
        int unsigned acc;
        t = v;
        acc = 0;
        e.err = 1'b0;
        for (int i = n - 1; i >= 0; i--) begin
            if (((t >> (4 * i)) & 16'hF) > 16'd9) e.err = 1'b1;
            acc = acc * 10 + int'((t >> (4 * i)) & 16'hF);
        end
        e.valor = e.err ? 0 : acc;
        return e;
    endfunction

    // Drive a start pulse across one accept edge and queue the expectation.
    task automatic lanzar(input logic [15:0] v);
        @(negedge clk);
        iniciar   = 1'b1;
        bcd_input = v;
        @(posedge clk);
        #1;
        iniciar   = 1'b0;
        bcd_input = 16'hFFFF;
        cola.push_back(modelo(v, 4));
    endtask

    // Count cycles until listo, with a bound; also counts cycles with ocupado high.
    task automatic esperar_listo(output int ciclos, output int ocup);
        ciclos = 0;
        ocup   = ocupado ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            ciclos++;
            if (listo) break;
            if (ocupado) ocup++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; iniciar = 1'b0; bcd_input = '0; iniciar2 = 1'b0; bcd_input2 = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        total++; if (numero_output !== 14'd0) $display("FAIL reset_numero got %0d want 0", numero_output); else passed++;
        total++; if (listo !== 1'b0) $display("FAIL reset_listo got %b want 0", listo); else passed++;
        total++; if (ocupado !== 1'b0) $display("FAIL reset_ocupado got %b want 0", ocupado); else passed++;
        total++; if (error_bcd !== 1'b0) $display("FAIL reset_error got %b want 0", error_bcd); else passed++;
        total++; if (numero_output2 !== 7'd0 || listo2 !== 1'b0 || ocupado2 !== 1'b0)
            $display("FAIL reset_dut2 got %0d/%b/%b want 0/0/0", numero_output2, listo2, ocupado2); else passed++;
        $display("reset: numero=%0d listo=%b ocupado=%b error=%b", numero_output, listo, ocupado, error_bcd);
    endtask

    task automatic convertir(input string nombre, input logic [15:0] v);
        int ciclos, ocup;
        esperado_t e;
        lanzar(v);
        esperar_listo(ciclos, ocup);
        e = cola.pop_front();
        total++; if (ciclos !== 4) $display("FAIL %s_latencia got %0d want 4", nombre, ciclos); else passed++;
        total++; if (ocup !== 4) $display("FAIL %s_ocupado got %0d want 4", nombre, ocup); else passed++;
        total++; if (ocupado !== 1'b0) $display("FAIL %s_listo_ocupado got ocupado=%b want 0", nombre, ocupado); else passed++;
        total++; if (numero_output !== 14'(e.valor)) $display("FAIL %s_valor got %0d want %0d", nombre, numero_output, e.valor); else passed++;
        total++; if (error_bcd !== e.err) $display("FAIL %s_error got %b want %b", nombre, error_bcd, e.err); else passed++;
        $display("%s: bcd=%h numero=%0d error=%b ciclos=%0d", nombre, v, numero_output, error_bcd, ciclos);
        @(posedge clk);
        #1;
        total++; if (listo !== 1'b0) $display("FAIL %s_pulso got listo=%b want 0", nombre, listo); else passed++;
    endtask

    task automatic test_basico;
        convertir("v1234", 16'h1234);
        convertir("v9999", 16'h9999);
        convertir("v0000", 16'h0000);
    endtask

    task automatic test_invalido;
        convertir("v12A4", 16'h12A4);
        convertir("v0003", 16'h0003);
    endtask

    task automatic test_back_to_back;
        int ciclos;
        esperado_t e;
        ciclos = 0;
        lanzar(16'h0042);
        @(posedge clk); #1;
        ciclos++;
        iniciar = 1'b1; bcd_input = 16'h5555;
        @(posedge clk); #1;
        ciclos++;
        iniciar = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (listo) break;
            @(posedge clk); #1;
            ciclos++;
        end
        e = cola.pop_front();
        total++; if (numero_output !== 14'(e.valor) || ciclos !== 4)
            $display("FAIL ignorar got %0d after %0d want %0d after 4", numero_output, ciclos, e.valor); else passed++;
        $display("ignorar: numero=%0d ciclos=%0d", numero_output, ciclos);
        // Start held during the listo cycle is accepted on the next edge.
        iniciar = 1'b1; bcd_input = 16'h0007;
        @(posedge clk); #1;
        iniciar = 1'b0;
        cola.push_back(modelo(16'h0007, 4));
        total++; if (ocupado !== 1'b1) $display("FAIL b2b_aceptado got ocupado=%b want 1", ocupado); else passed++;
        ciclos = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            ciclos++;
            if (listo) break;
        end
        e = cola.pop_front();
        total++; if (numero_output !== 14'(e.valor) || ciclos !== 4)
            $display("FAIL b2b got %0d after %0d want %0d after 4", numero_output, ciclos, e.valor); else passed++;
        $display("b2b: numero=%0d ciclos=%0d", numero_output, ciclos);
    endtask

    task automatic test_rst_abort;
        int pulsos;
        lanzar(16'h8888);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        void'(cola.pop_back());
        total++; if (numero_output !== 14'd0 || ocupado !== 1'b0 || listo !== 1'b0 || error_bcd !== 1'b0)
            $display("FAIL abort_salidas got %0d/%b/%b/%b want 0/0/0/0", numero_output, ocupado, listo, error_bcd); else passed++;
        pulsos = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (listo) pulsos++;
        end
        total++; if (pulsos !== 0) $display("FAIL abort_sin_listo got %0d pulses want 0", pulsos); else passed++;
        $display("abort: numero=%0d pulsos=%0d", numero_output, pulsos);
        convertir("v0100", 16'h0100);
    endtask

    task automatic test_param;
        int ciclos;
        esperado_t e;
        @(negedge clk);
        iniciar2 = 1'b1; bcd_input2 = 8'h99;
        @(posedge clk); #1;
        iniciar2 = 1'b0; bcd_input2 = 8'h00;
        cola.push_back(modelo(16'h0099, 2));
        ciclos = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            ciclos++;
            if (listo2) break;
        end
        e = cola.pop_front();
        total++; if (numero_output2 !== 7'(e.valor)) $display("FAIL param_valor got %0d want %0d", numero_output2, e.valor); else passed++;
        total++; if (ciclos !== 2) $display("FAIL param_latencia got %0d want 2", ciclos); else passed++;
        $display("param: numero=%0d ciclos=%0d", numero_output2, ciclos);
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_basico();
        test_invalido();
        test_back_to_back();
        test_rst_abort();
        test_param();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
